// File: rtl/cs_approx_avg_pkg.sv
// rtl/cs_approx_avg_pkg.sv - shared widths, sample type and x9 helper for the approximate-average smoother
package cs_approx_avg_pkg;

  localparam int W_IN  = 8;
  localparam int N_TAP = 9;
  localparam int W_OUT = 10;
  localparam int W_SUM = 13;

  typedef logic [W_IN-1:0]  sample_t;
  typedef logic [W_SUM-1:0] sum_t;

  // 9*v as shift-and-add so no multiplier is inferred
  function automatic sum_t times_nine(input sample_t v);
    return sum_t'({v, 3'b000}) + sum_t'(v);
  endfunction

endpackage

// File: rtl/cs_appr_select.sv
// rtl/cs_appr_select.sv - picks the largest window sample not exceeding the window mean
module cs_appr_select
  import cs_approx_avg_pkg::*;
(
  input  sample_t win [N_TAP],
  input  sum_t    sum,
  output sample_t xappr
);

  sample_t masked [N_TAP];
  sample_t best;

  // Compare 9*Wi against the sum (exact, no divide); failing taps are zeroed,
  // then the largest survivor is taken. The window minimum always passes, and a
  // zero from masking can never beat it unless it is itself the right answer.
  always_comb begin
    best = '0;
    for (int i = 0; i < N_TAP; i++) begin
      masked[i] = (times_nine(win[i]) <= sum) ? win[i] : '0;
    end
    for (int i = 0; i < N_TAP; i++) begin
      if (masked[i] > best) best = masked[i];
    end
    xappr = best;
  end

endmodule

// File: rtl/cs_approx_avg.sv
// rtl/cs_approx_avg.sv - 9-tap approximate-average smoother top; optional out_valid under CS_VALID_EN
module cs_approx_avg
  import cs_approx_avg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [W_IN-1:0]  X,
  output logic [W_OUT-1:0] Y
`ifdef CS_VALID_EN
  ,
  output logic             out_valid
`endif
);

  // hist[0] is the newest stored sample; X itself is the ninth tap this cycle
  sample_t hist [N_TAP-1];
  sample_t win  [N_TAP];
  sum_t    sum;
  sample_t xappr;
  sum_t    acc;

  // Assemble the window as seen at this edge and add it up
  always_comb begin
    win[0] = X;
    for (int i = 1; i < N_TAP; i++) begin
      win[i] = hist[i-1];
    end
    sum = '0;
    for (int i = 0; i < N_TAP; i++) begin
      sum = sum + sum_t'(win[i]);
    end
  end

  cs_appr_select u_appr_select (
    .win   (win),
    .sum   (sum),
    .xappr (xappr)
  );

  // Final combine: max 2295 + 2295 = 4590 still fits the 13-bit sum type
  always_comb begin
    acc = sum + times_nine(xappr);
  end

  // Shift the window and register the result on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_TAP-1; i++) begin
        hist[i] <= '0;
      end
      Y <= '0;
    end else begin
      hist[0] <= X;
      for (int i = 1; i < N_TAP-1; i++) begin
        hist[i] <= hist[i-1];
      end
      Y <= acc[W_SUM-1:3];
    end
  end

`ifdef CS_VALID_EN
  logic [3:0] fill_cnt;

  // Count captured samples up to 9; valid goes high on the edge taking the 9th
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (fill_cnt != 4'd9) fill_cnt <= fill_cnt + 4'd1;
      out_valid <= (fill_cnt >= 4'd8);
    end
  end
`endif

endmodule

// File: tb/tb_cs_approx_avg.sv
// tb/tb_cs_approx_avg.sv - scoreboard bench for cs_approx_avg (directed vectors, reset restart, random stream)
`timescale 1ns/1ps
module tb_cs_approx_avg;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] X;
  logic [9:0] Y;
`ifdef CS_VALID_EN
  logic       out_valid;
  int         fill;
`endif

  int n_vec = 0;
  int n_err = 0;
  int hist [8];
  int exp_q [$];

  always #4.5 clk = ~clk;

  cs_approx_avg dut (
    .clk   (clk),
    .reset (reset),
    .X     (X),
    .Y     (Y)
`ifdef CS_VALID_EN
    ,
    .out_valid (out_valid)
`endif
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Golden: largest sample <= floor(mean), found via integer division
  function automatic int model(input int x);
    int s, m, best;
    int w [9];
    w[0] = x;
    for (int i = 0; i < 8; i++) w[i+1] = hist[i];
    s = 0;
    for (int i = 0; i < 9; i++) s += w[i];
    m = s / 9;
    best = 0;
    for (int i = 0; i < 9; i++) if (w[i] <= m && w[i] > best) best = w[i];
    return (s + 9 * best) / 8;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) hist[i] = 0;
`ifdef CS_VALID_EN
    fill = 0;
`endif
  endtask

  task automatic apply(input logic [7:0] v);
    X = v;
    exp_q.push_back(model(int'(v)));
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = int'(v);
`ifdef CS_VALID_EN
    if (fill < 9) fill++;
`endif
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) check("queue_empty", 1, 0);
    else check("y_scoreboard", int'(Y), exp_q.pop_front());
`ifdef CS_VALID_EN
    check("out_valid", int'(out_valid), (fill == 9) ? 1 : 0);
`endif
  endtask

  initial begin
    reset = 1'b0;
    X = 8'h00;
    clear_model();
    #1;
    check("reset_y", int'(Y), 0);
`ifdef CS_VALID_EN
    check("reset_valid", int'(out_valid), 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    clear_model();
    // the edge above captured X=0 into a zero window, so the model is still all-zero
    check("idle_zero", int'(Y), 0);
`ifdef CS_VALID_EN
    // that edge already counted one sample
    fill = 1;
`endif

    for (int i = 0; i < 9; i++) apply(8'h10);
    check("t1_flat16", int'(Y), 'h024);

    for (int i = 0; i < 9; i++) apply(8'hFF);
    check("t2_max", int'(Y), 'h23D);

    for (int i = 1; i <= 9; i++) apply(8'(i));
    check("t3_ramp", int'(Y), 'h00B);

    for (int i = 0; i < 8; i++) apply(8'h00);
    apply(8'h5A);
    check("t4_spike", int'(Y), 'h00B);

    for (int i = 0; i < 8; i++) apply(8'h0A);
    apply(8'h13);
    check("t5_step", int'(Y), 'h017);

    // asynchronous reset in the middle of a cycle
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_y", int'(Y), 0);
`ifdef CS_VALID_EN
    check("t6_async_valid", int'(out_valid), 0);
`endif
    clear_model();
    @(posedge clk);
    #1;
    check("t6_hold_y", int'(Y), 0);
    @(negedge clk);
    reset = 1'b1;
    apply(8'h10);
    check("t6_first", int'(Y), 'h002);
    for (int i = 0; i < 8; i++) apply(8'h10);
    check("t6_ninth", int'(Y), 'h024);

    for (int i = 0; i < 2000; i++) apply(8'($urandom_range(0, 255)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
